// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the single-port SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } ctrl_state_e;

    localparam int unsigned DefBits      = 256;
    localparam int unsigned DefAddrWidth = 12;
    localparam int unsigned DefRspDepth  = 4;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer: circular FIFO with valid/ready on both ends.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned Width = DefBits,
    parameter int unsigned Depth = DefRspDepth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push_valid,
    output logic                         o_push_ready,
    input  logic [Width-1:0]             i_push_data,
    output logic                         o_pop_valid,
    input  logic                         i_pop_ready,
    output logic [Width-1:0]             o_pop_data,
    output logic [$clog2(Depth+1)-1:0]   o_count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_push_ready = (r_count != CntW'(Depth));
    assign o_pop_valid  = (r_count != '0);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;
    assign o_count      = r_count;
    // An occupied slot is never rewritten, so the head stays stable under stall.
    assign o_pop_data   = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_data;
    end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Request/response front end for an external 1RW SRAM macro with optional zero-fill after reset.
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BITS       = DefBits,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RSP_DEPTH  = DefRspDepth,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS-1:0]       req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_w_mask,
    input  logic [BITS-1:0]       sram_rd,
    output logic                  init_done
);

    localparam int unsigned        CntW       = $clog2(RSP_DEPTH + 1);
    localparam logic [CntW:0]      DepthLim   = RSP_DEPTH[CntW:0];
    localparam ctrl_state_e        ResetState = (INIT_ZERO != 0) ? StInit : StRun;

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_next;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  r_inflight;
    logic [CntW-1:0]       w_fifo_count;
    logic [CntW:0]         w_occupancy;
    logic                  w_fifo_push_ready;
    logic                  w_read_credit;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_last_init;

    // A pop in the current cycle is deliberately not credited, keeping
    // req_ready independent of rsp_ready.
    assign w_occupancy   = {1'b0, w_fifo_count} + {{CntW{1'b0}}, r_inflight};
    assign w_read_credit = (w_occupancy < DepthLim) && w_fifo_push_ready;
    assign w_can_accept  = (r_state == StRun) && (req_we || w_read_credit);
    assign w_accept      = req_valid && w_can_accept;
    assign w_last_init   = (r_init_addr == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ResetState;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StInit:  if (w_last_init) w_state_next = StRun;
            StRun:   w_state_next = StRun;
        endcase
    end

    // rst_n gating only reaches ports so outputs drop the instant reset asserts.
    always_comb begin
        req_ready   = 1'b0;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = req_addr;
        sram_wd     = req_wdata;
        sram_w_mask = req_wmask;
        init_done   = 1'b0;
        unique case (r_state)
            StInit: begin
                sram_ce     = rst_n;
                sram_we     = rst_n;
                sram_addr   = r_init_addr;
                sram_wd     = '0;
                sram_w_mask = '1;
            end
            StRun: begin
                req_ready = rst_n && w_can_accept;
                sram_ce   = rst_n && w_accept;
                sram_we   = rst_n && w_accept && req_we;
                init_done = rst_n;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_addr <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (r_state == StInit) r_init_addr <= r_init_addr + 1'b1;
            r_inflight <= w_accept && !req_we;
        end
    end

    sram_rsp_fifo #(
        .Width (BITS),
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (r_inflight),
        .o_push_ready (w_fifo_push_ready),
        .i_push_data  (sram_rd),
        .o_pop_valid  (rsp_valid),
        .i_pop_ready  (rsp_ready),
        .o_pop_data   (rsp_rdata),
        .o_count      (w_fifo_count)
    );

endmodule
